// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one fixed-latency memory port between an
// instruction-fetch requester (read-only) and a data requester (read/write).
// Data side has priority; fetch is forced after STARVE_LIMIT consecutive
// data grants taken while fetch was waiting.
// Optional statistics counters are enabled with the ARB_STATS_EN macro.
module mem_port_arbiter #(
   parameter int unsigned WORD_SIZE    = 16,
   parameter int unsigned MEM_LATENCY  = 2,
   parameter int unsigned STARVE_LIMIT = 3
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 i_req,
   input  logic [WORD_SIZE-1:0] i_address,
   output logic                 i_ack,
   output logic [WORD_SIZE-1:0] i_rdata,
   input  logic                 d_req,
   input  logic                 d_write,
   input  logic [WORD_SIZE-1:0] d_address,
   input  logic [WORD_SIZE-1:0] d_wdata,
   output logic                 d_ack,
   output logic [WORD_SIZE-1:0] d_rdata,
   output logic                 m_readM,
   output logic                 m_writeM,
   output logic [WORD_SIZE-1:0] m_address,
   output logic [WORD_SIZE-1:0] m_wdata,
   input  logic [WORD_SIZE-1:0] m_rdata,
   output logic                 busy
`ifdef ARB_STATS_EN
   ,
   output logic [WORD_SIZE-1:0] num_i_grant,
   output logic [WORD_SIZE-1:0] num_d_grant,
   output logic [WORD_SIZE-1:0] num_conflict
`endif
);

   localparam int unsigned CNT_W    = 4;
   localparam int unsigned STARVE_W = 4;

   typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, ACK} state_t;

   state_t              state;
   state_t              state_nxt;
   logic [CNT_W-1:0]    cnt;
   logic [STARVE_W-1:0] starve_cnt;
   logic                owner;      // 1 = data requester owns the access
   logic                wr;         // current access is a data write
   logic                grant_i;
   logic                grant_d;
   logic                done;
   logic                starved;
   logic                in_busy;

   assign starved = (starve_cnt == STARVE_W'(STARVE_LIMIT));
   assign in_busy = (state == BUSY_I) || (state == BUSY_D);

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   // Next-state logic and grant/completion decode
   always_comb begin
      state_nxt = state;
      grant_i   = 1'b0;
      grant_d   = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE: begin
            if (d_req && !(i_req && starved)) begin
               grant_d   = 1'b1;
               state_nxt = BUSY_D;
            end else if (i_req) begin
               grant_i   = 1'b1;
               state_nxt = BUSY_I;
            end
         end
         BUSY_I, BUSY_D: begin
            if (cnt == '0) begin
               done      = 1'b1;
               state_nxt = ACK;
            end
         end
         ACK:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Access datapath: grant capture, latency count, read-data return, ack pulse
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_address <= '0;
         m_wdata   <= '0;
         m_readM   <= 1'b0;
         m_writeM  <= 1'b0;
         owner     <= 1'b0;
         wr        <= 1'b0;
         cnt       <= '0;
         busy      <= 1'b0;
         i_ack     <= 1'b0;
         d_ack     <= 1'b0;
         i_rdata   <= '0;
         d_rdata   <= '0;
      end else begin
         if (grant_i || grant_d) begin
            m_address <= grant_d ? d_address : i_address;
            m_wdata   <= grant_d ? d_wdata : '0;
            owner     <= grant_d;
            wr        <= grant_d && d_write;
            cnt       <= CNT_W'(MEM_LATENCY - 1);
            m_readM   <= !(grant_d && d_write);
            m_writeM  <= grant_d && d_write;
            busy      <= 1'b1;
         end
         if (in_busy && (cnt != '0)) cnt <= cnt - CNT_W'(1);
         if (done) begin
            m_readM  <= 1'b0;
            m_writeM <= 1'b0;
            if (!wr) begin
               if (owner) d_rdata <= m_rdata;
               else       i_rdata <= m_rdata;
            end
            i_ack <= !owner;
            d_ack <= owner;
         end
         if (state == ACK) begin
            i_ack <= 1'b0;
            d_ack <= 1'b0;
            busy  <= 1'b0;
         end
      end
   end

   // Anti-starvation counter: data grants taken while fetch is waiting
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                       starve_cnt <= '0;
      else if (grant_i)                   starve_cnt <= '0;
      else if (grant_d && i_req && !starved) starve_cnt <= starve_cnt + STARVE_W'(1);
   end

`ifdef ARB_STATS_EN
   // Saturating grant and conflict statistics
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         num_i_grant  <= '0;
         num_d_grant  <= '0;
         num_conflict <= '0;
      end else begin
         if (grant_i && (num_i_grant != '1)) num_i_grant <= num_i_grant + WORD_SIZE'(1);
         if (grant_d && (num_d_grant != '1)) num_d_grant <= num_d_grant + WORD_SIZE'(1);
         if ((state == IDLE) && i_req && d_req && (num_conflict != '1))
            num_conflict <= num_conflict + WORD_SIZE'(1);
      end
   end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (default parameters).
// Memory model: address 0x0010 returns 0xABCD, every other address
// returns address ^ 0xA5A5.
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        i_req;
   logic [15:0] i_address;
   logic        i_ack;
   logic [15:0] i_rdata;
   logic        d_req;
   logic        d_write;
   logic [15:0] d_address;
   logic [15:0] d_wdata;
   logic        d_ack;
   logic [15:0] d_rdata;
   logic        m_readM;
   logic        m_writeM;
   logic [15:0] m_address;
   logic [15:0] m_wdata;
   logic [15:0] m_rdata;
   logic        busy;
`ifdef ARB_STATS_EN
   logic [15:0] num_i_grant;
   logic [15:0] num_d_grant;
   logic [15:0] num_conflict;
`endif

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   assign m_rdata = (m_address == 16'h0010) ? 16'hABCD : (m_address ^ 16'hA5A5);

   mem_port_arbiter dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .i_req     (i_req),
      .i_address (i_address),
      .i_ack     (i_ack),
      .i_rdata   (i_rdata),
      .d_req     (d_req),
      .d_write   (d_write),
      .d_address (d_address),
      .d_wdata   (d_wdata),
      .d_ack     (d_ack),
      .d_rdata   (d_rdata),
      .m_readM   (m_readM),
      .m_writeM  (m_writeM),
      .m_address (m_address),
      .m_wdata   (m_wdata),
      .m_rdata   (m_rdata),
      .busy      (busy)
`ifdef ARB_STATS_EN
      ,
      .num_i_grant  (num_i_grant),
      .num_d_grant  (num_d_grant),
      .num_conflict (num_conflict)
`endif
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      logic exp_d;
      reset_n   = 1'b0;
      i_req     = 1'b0;
      i_address = '0;
      d_req     = 1'b0;
      d_write   = 1'b0;
      d_address = '0;
      d_wdata   = '0;

      // Reset state
      #2;
      check("rst_busy", busy, 0);
      check("rst_m_readM", m_readM, 0);
      check("rst_i_ack", i_ack, 0);
      check("rst_d_rdata", d_rdata, 0);
      @(posedge clk);
      @(posedge clk);
      #1 reset_n = 1'b1;

      // Single fetch from 0x0010
      i_req = 1'b1; i_address = 16'h0010;
      tick();
      check("f_rd1", m_readM, 1);
      check("f_addr", m_address, 16'h0010);
      check("f_wd", m_wdata, 0);
      check("f_ack_early", i_ack, 0);
      tick();
      check("f_rd2", m_readM, 1);
      tick();
      check("f_ack", i_ack, 1);
      check("f_rdata", i_rdata, 16'hABCD);
      check("f_rd_ack", m_readM, 0);
      check("f_busy_ack", busy, 1);
      i_req = 1'b0;
      tick();
      check("f_ack_end", i_ack, 0);
      check("f_busy_idle", busy, 0);

      // Data write 0x1234 to 0x0200
      d_req = 1'b1; d_write = 1'b1; d_address = 16'h0200; d_wdata = 16'h1234;
      tick();
      check("w_wr1", m_writeM, 1);
      check("w_rd1", m_readM, 0);
      check("w_addr", m_address, 16'h0200);
      check("w_wdata", m_wdata, 16'h1234);
      tick();
      check("w_wr2", m_writeM, 1);
      tick();
      check("w_ack", d_ack, 1);
      check("w_rdata_kept", d_rdata, 0);
      check("w_wr_ack", m_writeM, 0);
      d_req = 1'b0;
      tick();
      check("w_ack_end", d_ack, 0);

      // Data read from 0x0300
      d_req = 1'b1; d_write = 1'b0; d_address = 16'h0300;
      tick();
      check("r_rd1", m_readM, 1);
      check("r_wr1", m_writeM, 0);
      tick(); tick();
      check("r_ack", d_ack, 1);
      check("r_rdata", d_rdata, 16'hA6A5);
      check("r_i_ack", i_ack, 0);
      d_req = 1'b0;
      tick();

      // Both requesters held: expect D,D,D,I,D,D,D,I
      i_req = 1'b1; i_address = 16'h0040;
      d_req = 1'b1; d_write = 1'b0; d_address = 16'h0100;
      for (int k = 0; k < 8; k++) begin
         exp_d = (k % 4) != 3;
         tick();
         check($sformatf("s%0d_addr", k), m_address, exp_d ? 16'h0100 : 16'h0040);
         tick(); tick();
         check($sformatf("s%0d_d_ack", k), d_ack, exp_d);
         check($sformatf("s%0d_i_ack", k), i_ack, !exp_d);
         if (exp_d) check($sformatf("s%0d_d_rdata", k), d_rdata, 16'hA4A5);
         else       check($sformatf("s%0d_i_rdata", k), i_rdata, 16'hA5E5);
         if (k == 7) begin
            i_req = 1'b0;
            d_req = 1'b0;
         end
         tick();
         check($sformatf("s%0d_idle", k), busy, 0);
      end

`ifdef ARB_STATS_EN
      check("st_i_grant", num_i_grant, 3);
      check("st_d_grant", num_d_grant, 8);
      check("st_conflict", num_conflict, 8);
`endif

      // Back-to-back fetches from 0x0020: acks every 4 cycles
      i_req = 1'b1; i_address = 16'h0020;
      for (int k = 1; k < 12; k++) begin
         tick();
         check($sformatf("b2b_ack%0d", k), i_ack, (k % 4) == 3);
         check($sformatf("b2b_busy%0d", k), busy, (k % 4) != 0);
         if (k == 11) i_req = 1'b0;
      end
      check("b2b_rdata", i_rdata, 16'hA585);
      tick();
      check("b2b_end_ack", i_ack, 0);
      check("b2b_end_busy", busy, 0);

      // Reset during the first BUSY_D cycle
      d_req = 1'b1; d_write = 1'b0; d_address = 16'h0100;
      tick();
      check("mr_busy_pre", m_readM, 1);
      reset_n = 1'b0;
      #1;
      check("mr_busy", busy, 0);
      check("mr_m_readM", m_readM, 0);
      check("mr_m_addr", m_address, 0);
      check("mr_d_rdata", d_rdata, 0);
      check("mr_i_rdata", i_rdata, 0);
      d_req = 1'b0;
      @(posedge clk);
      #1 reset_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         check($sformatf("mr_no_ack%0d", k), d_ack, 0);
         check($sformatf("mr_idle%0d", k), busy, 0);
      end
`ifdef ARB_STATS_EN
      check("mr_st_i", num_i_grant, 0);
`endif
      i_req = 1'b1; i_address = 16'h0010;
      tick(); tick(); tick();
      check("mr_f_ack", i_ack, 1);
      check("mr_f_rdata", i_rdata, 16'hABCD);
      i_req = 1'b0;
      tick();
      check("mr_f_end", i_ack, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one fixed-latency unified memory port between the pipeline's instruction-fetch requester (read-only) and data-access requester (read/write).
- Sits between the datapath's i_readM/d_readM/d_writeM interface and the single memory model.
- Serialises accesses, counts memory latency, returns read data with a one-cycle ack pulse.
- Gives data side priority, bounded by an anti-starvation counter for fetch.

Parameters:
WORD_SIZE, 16, address/data width
MEM_LATENCY, 2, cycles the memory command is held per access (1..15)
STARVE_LIMIT, 3, consecutive data grants with fetch waiting before fetch is forced (1..15)

Ports:
clk  input  1  clock, rising edge
reset_n  input  1  asynchronous active-low reset
i_req  input  1  fetch request; held with i_address until i_ack
i_address  input  WORD_SIZE  fetch address
i_ack  output  1  one-cycle pulse: fetch done, i_rdata valid
i_rdata  output  WORD_SIZE  fetched word, registered
d_req  input  1  data request; held with d_write/d_address/d_wdata until d_ack
d_write  input  1  1 = write, 0 = read
d_address  input  WORD_SIZE  data address
d_wdata  input  WORD_SIZE  write data
d_ack  output  1  one-cycle pulse: data access done, d_rdata valid for reads
d_rdata  output  WORD_SIZE  read word, registered
m_readM  output  1  memory read command
m_writeM  output  1  memory write command
m_address  output  WORD_SIZE  memory address, registered at grant
m_wdata  output  WORD_SIZE  memory write data, registered at grant
m_rdata  input  WORD_SIZE  memory read data, valid in last BUSY cycle
busy  output  1  high in BUSY_I, BUSY_D, ACK

Behaviour:
- Clock and reset: one clock, clk; reset_n is asynchronous, active-low.
- Reset: state IDLE; all outputs 0; cnt, starve_cnt and owner cleared. Reset mid-access aborts with no ack.
- FSM states: IDLE, BUSY_I, BUSY_D, ACK.
- IDLE, neither request: stay in IDLE.
- IDLE, one request: grant it.
- IDLE, both requests: grant data, unless starve_cnt == STARVE_LIMIT, then grant fetch.
- On grant edge:
  - Register m_address and m_wdata; m_wdata = 0 for fetch.
  - Record owner; cnt <= MEM_LATENCY-1.
  - Enter BUSY_I, or BUSY_D.
- BUSY_x:
  - m_readM = 1, except m_writeM = 1 for a data write; the two are never both high.
  - Stay while cnt != 0; decrement cnt each edge.
  - At cnt == 0: capture m_rdata into the owner's rdata (reads only; writes leave rdata unchanged); go to ACK.
- ACK: the owner's ack = 1 for exactly this cycle; m_* commands 0; no grant; next state IDLE.
- Latency: request first seen in IDLE cycle t. BUSY occupies t+1..t+MEM_LATENCY. Ack in cycle t+MEM_LATENCY+1.
- Back-to-back accesses leave one IDLE cycle between ack and the next BUSY.
- Starvation counter:
  - starve_cnt increments (saturating at STARVE_LIMIT) on each data grant made while i_req is high.
  - Clears on any fetch grant.
  - Unchanged on a data grant with i_req low.
- Requests are sampled only in IDLE. A request dropped mid-access is a protocol violation; the access still completes and ack still pulses.
- rdata registers hold their value between acks.
- Requester may deassert req in the ack cycle, or keep it high for a new access, which is granted in the following IDLE cycle.

Optional Feature:
- Macro ARB_STATS_EN.
- Defined:
  - Adds outputs num_i_grant, num_d_grant, num_conflict (each WORD_SIZE).
  - num_i_grant and num_d_grant increment per grant.
  - num_conflict increments per IDLE cycle with both requests high.
  - All three saturate at all-ones and reset to 0.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- Single fetch: i_req=1, i_address=0x0010, MEM_LATENCY=2, memory returns 0xABCD -> m_readM high 2 cycles, m_address=0x0010, i_ack in 4th cycle after request, i_rdata=0xABCD.
- Data write: d_req=1, d_write=1, d_address=0x0200, d_wdata=0x1234 -> m_writeM high 2 cycles, m_wdata=0x1234, m_readM=0, d_ack pulsed once, d_rdata unchanged.
- Simultaneous requests from IDLE, i_req and d_req held continuously (d re-requests after each ack) -> grant order D,D,D,I,D,D,D,I; starve_cnt 1,2,3 then 0.
- Back-to-back fetches with i_req held -> acks 4 cycles apart (one IDLE bubble between them); no double ack.
- reset_n low during BUSY_D cycle 1 -> immediately state IDLE, all outputs 0, no d_ack; after release a new fetch completes normally.
- ARB_STATS_EN defined, 3 conflicting IDLE cycles, 5 fetch grants, 4 data grants -> num_conflict=3, num_i_grant=5, num_d_grant=4; counter preloaded at 0xFFFF stays at 0xFFFF.
